parity_stream: RTL

PARITY_STREAM -- requirements
Module: parity_stream

---
 rtl/parity_stream.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/parity_stream.sv
// -----------------------------------------------------------------------------
// parity_stream
//
// Accumulates parity over a framed stream of data beats and presents one
// result per frame:
//   * row parity    - XOR of every bit of every beat (optionally inverted)
//   * column parity - bitwise XOR of all beats
//   * beat count    - saturating at 2^CNT_W-1
//   * error flag    - row parity compared against an expected value
//
// The frame result is registered on the last beat and held until it is
// consumed. While a result is held the input side is stalled (in_ready=0),
// so at least two cycles separate consecutive frame results.
//
// Parameters
//   WIDTH  data beat width in bits (>= 1)
//   CNT_W  beat counter width in bits (>= 1)
//   ODD    parity sense: 0 = even, 1 = odd
//
// Compile-time option
//   PARITY_STREAM_ERR_EN  when defined, out_err is registered on the last
//                         beat as (row parity ^ ODD) != in_exp. When not
//                         defined, in_exp is accepted but ignored and out_err
//                         is tied to 0.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    beat offered
//   in_ready    beat can be accepted (high unless a result is held)
//   in_data     beat payload
//   in_last     final beat of frame
//   in_exp      expected frame parity, qualified with the last beat
//   out_valid   frame result available
//   out_ready   frame result consumed
//   out_parity  frame row parity bit
//   out_col     column parity (XOR of all beats)
//   out_beats   saturated beat count of the frame
//   out_err     parity mismatch flag
// -----------------------------------------------------------------------------
module parity_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [WIDTH-1:0] out_col,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no beat held
    ACC  = 2'd1,  // at least one beat, last beat not yet seen
    DONE = 2'd2   // frame result held
  } state_t;

  state_t state;
  state_t state_nxt;

  // Running accumulators for the frame in progress.
  logic             row_acc;
  logic [WIDTH-1:0] col_acc;
  logic [CNT_W-1:0] count;

  // Accumulator values after folding in the current beat.
  logic             row_base;
  logic [WIDTH-1:0] col_base;
  logic [CNT_W-1:0] cnt_base;
  logic             row_nxt;
  logic [WIDTH-1:0] col_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  logic accept;       // beat taken this cycle
  logic accept_last;  // last beat of a frame taken this cycle
  logic consume;      // held result handed off this cycle

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign in_ready    = (state != DONE);
  assign accept      = in_valid & in_ready;
  assign accept_last = accept & in_last;
  assign consume     = (state == DONE) & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator update
  // ---------------------------------------------------------------------------
  // In IDLE the accumulators are treated as zero, so a new frame always
  // starts clean even if stale values were left in the registers.
  always_comb begin
    row_base = 1'b0;
    col_base = '0;
    cnt_base = '0;
    if (state != IDLE) begin
      row_base = row_acc;
      col_base = col_acc;
      cnt_base = count;
    end

    row_nxt = row_base ^ (^in_data);
    col_nxt = col_base ^ in_data;
    cnt_nxt = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // NOTE: every register, data as well as control, has an async reset value
  // so a reset mid-frame leaves nothing behind for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_acc <= 1'b0;
      col_acc <= '0;
      count   <= '0;
    end else if (accept) begin
      row_acc <= row_nxt;
      col_acc <= col_nxt;
      count   <= cnt_nxt;
    end else if (consume) begin
      row_acc <= 1'b0;
      col_acc <= '0;
      count   <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  // Results are loaded from the post-beat accumulator values so the frame
  // result is visible the cycle after the last beat. On consumption only
  // out_valid drops; the data fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_col    <= '0;
      out_beats  <= '0;
    end else if (accept_last) begin
      out_valid  <= 1'b1;
      out_parity <= row_nxt ^ ODD;
      out_col    <= col_nxt;
      out_beats  <= cnt_nxt;
    end else if (consume) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef PARITY_STREAM_ERR_EN
  // Error flag is captured with the parity bit, from in_exp of the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err <= 1'b0;
    end else if (accept_last) begin
      out_err <= (row_nxt ^ ODD) != in_exp;
    end
  end
`else
  // Error checking compiled out: in_exp is kept on the port but unused.
  logic unused_in_exp;
  assign unused_in_exp = in_exp;
  assign out_err       = 1'b0;
`endif

endmodule
